imem_responder: RTL and testbench

Instruction-memory responder on the fetch interface: the target end that answers PC-driven fetch requests. Accepts word addresses over a valid/ready request channel, looks them up in an internal word array mapped at the text segment base, and returns instruction, address and error flag over a valid/ready response channel after a fixed latency. Sits between the program counter/fetch stage and the decode stage. Includes a load port used by the bench and the boot path to fill the array.

---
 rtl/imem_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/imem_responder.sv | 166 ++++++++++++++++
 tb/tb_imem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, defaults and address decode for the instruction-memory responder
package imem_pkg;

    localparam logic [31:0] TEXT_BASE_DEF   = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD_DEF    = 32'h0000_0000;
    localparam int unsigned DEPTH_WORDS_DEF = 1024;

    // One response in flight: echoed address, fetched word and error flag
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } entry_t;

    // Result of decoding a fetch address against the text segment
    typedef struct packed {
        logic        err;
        logic [31:0] index;
    } check_t;

    // Range compare happens on the raw address before the subtraction so an
    // address below the base can never wrap around into a valid index.
    function automatic check_t addr_check(
        input logic [31:0] addr,
        input logic [31:0] base  = TEXT_BASE_DEF,
        input int unsigned depth = DEPTH_WORDS_DEF
    );
        check_t      r;
        logic [32:0] limit;
        logic [31:0] offset;
        limit   = {1'b0, base} + ({1'b0, 32'(depth)} << 2);
        r.err   = (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
        offset  = addr - base;
        r.index = r.err ? 32'd0 : {2'b00, offset[31:2]};
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head read
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_W'(DEPTH));
    assign count    = cnt;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = store[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clock) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fetch-side instruction memory with fixed-latency valid/ready responses
module imem_responder
    import imem_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE   = TEXT_BASE_DEF,
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] NOP_WORD    = NOP_WORD_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_addr,
    output logic [31:0]                    rsp_instr,
    output logic                           rsp_err,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_index,
    input  logic [31:0]                    load_data
);

    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
    localparam int unsigned CREDITS = LATENCY + 1;
    localparam int unsigned CNT_W   = $clog2(CREDITS + 1);
    localparam int unsigned FIFO_CW = $clog2(CREDITS + 1);

    logic [31:0]      mem [DEPTH_WORDS];
    check_t           req_chk;
    logic [IDX_W-1:0] rd_index;
    logic             req_fire;
    logic             rsp_fire;
    logic [CNT_W-1:0] cnt;

    logic             s1_valid;
    logic [31:0]      s1_addr;
    logic             s1_err;
    logic [31:0]      s1_rdata;
    entry_t           s1_entry;

    logic             tail_v;
    entry_t           tail_e;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_CW-1:0] fifo_count;
    entry_t           fifo_head;
    entry_t           out_e;

    logic             unused_decode;

    assign req_chk       = addr_check(req_addr, TEXT_BASE, DEPTH_WORDS);
    assign rd_index      = req_chk.index[IDX_W-1:0];
    assign unused_decode = |{req_chk.index[31:IDX_W], fifo_full, fifo_count};

    // The credit count is registered, so ready never depends on rsp_ready
    assign req_ready = (cnt < CNT_W'(CREDITS));
    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // Outstanding-response credits: pipeline plus output buffer
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (req_fire && !rsp_fire) begin
            cnt <= cnt + 1'b1;
        end else if (!req_fire && rsp_fire) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Array load and stage-1 synchronous read; a same-edge read returns old data
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem[load_index] <= load_data;
        end
        if (req_fire && !req_chk.err) begin
            s1_rdata <= mem[rd_index];
        end
    end

    // Stage-1 control: valid is reset, payload only moves on an accept
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= req_fire;
        end
        if (req_fire) begin
            s1_addr <= req_addr;
            s1_err  <= req_chk.err;
        end
    end

    // Errored fetches never read the array, so substitute the NOP here
    always_comb begin
        s1_entry       = '0;
        s1_entry.addr  = s1_addr;
        s1_entry.err   = s1_err;
        s1_entry.instr = s1_err ? NOP_WORD : s1_rdata;
    end

    generate
        if (LATENCY == 1) begin : g_no_delay
            assign tail_v = s1_valid;
            assign tail_e = s1_entry;
        end else begin : g_delay
            entry_t                dly_q [LATENCY-1];
            logic [LATENCY-2:0]    dly_v;

            // Plain delay stages between the array read and the output buffer
            always_ff @(posedge clock) begin
                if (reset) begin
                    dly_v <= '0;
                end else begin
                    dly_v[0] <= s1_valid;
                    for (int k = 1; k < int'(LATENCY) - 1; k++) begin
                        dly_v[k] <= dly_v[k-1];
                    end
                end
                dly_q[0] <= s1_entry;
                for (int k = 1; k < int'(LATENCY) - 1; k++) begin
                    dly_q[k] <= dly_q[k-1];
                end
            end

            assign tail_v = dly_v[LATENCY-2];
            assign tail_e = dly_q[LATENCY-2];
        end
    endgenerate

    // When the buffer is empty the tail is presented directly so the response
    // appears LATENCY cycles after accept; if it is not taken it drops into
    // the buffer and the same values reappear at the head next cycle.
    assign fifo_push = tail_v && !(fifo_empty && rsp_ready);
    assign fifo_pop  = !fifo_empty && rsp_ready;

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (CREDITS)
    ) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (tail_e),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Response mux; payload reads as zero whenever nothing is presented
    always_comb begin
        out_e     = fifo_empty ? tail_e : fifo_head;
        rsp_valid = tail_v || !fifo_empty;
        rsp_addr  = rsp_valid ? out_e.addr  : 32'd0;
        rsp_instr = rsp_valid ? out_e.instr : 32'd0;
        rsp_err   = rsp_valid ? out_e.err   : 1'b0;
    end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder
module tb_imem_responder;
    import imem_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_addr;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        load_en = 1'b0;
    logic [9:0]  load_index = 10'd0;
    logic [31:0] load_data = 32'd0;

    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    entry_t sb_q[$];
    int     pop_cyc[$];

    imem_responder #(
        .TEXT_BASE   (32'h0040_0000),
        .DEPTH_WORDS (1024),
        .LATENCY     (2),
        .NOP_WORD    (32'h0000_0000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_addr   (rsp_addr),
        .rsp_instr  (rsp_instr),
        .rsp_err    (rsp_err),
        .load_en    (load_en),
        .load_index (load_index),
        .load_data  (load_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented response against the scoreboard head
    initial begin
        entry_t e;
        forever begin
            @(negedge clock);
            if (!reset && rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb_q[0];
                    if (rsp_ready) begin
                        check("rsp_addr", rsp_addr, e.addr);
                        check("rsp_instr", rsp_instr, e.instr);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        void'(sb_q.pop_front());
                        pop_cyc.push_back(cyc);
                    end else begin
                        check("hold_addr", rsp_addr, e.addr);
                        check("hold_instr", rsp_instr, e.instr);
                        check("hold_err", 32'(rsp_err), 32'(e.err));
                    end
                end
            end
        end
    end

    // Called one step after a rising edge; returns one step after the next one
    task automatic load(input int idx, input logic [31:0] d);
        load_en    = 1'b1;
        load_index = 10'(idx);
        load_data  = d;
        @(posedge clock);
        #1;
        load_en = 1'b0;
    endtask

    // Present one request, wait (bounded) for acceptance, record the expectation
    task automatic send(input logic [31:0] a, input logic [31:0] ei, input logic ee, output int waits);
        entry_t e;
        req_valid = 1'b1;
        req_addr  = a;
        waits     = 0;
        @(negedge clock);
        while (!req_ready && waits < 50) begin
            waits++;
            @(negedge clock);
        end
        if (!req_ready) begin
            check("req_accept_timeout", 32'(req_ready), 32'd1);
        end else begin
            e.addr  = a;
            e.instr = ei;
            e.err   = ee;
            sb_q.push_back(e);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("drain_left", 32'(sb_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int w;
        int lat;
        logic [31:0] t2 [4];
        t2[0] = 32'h11; t2[1] = 32'h22; t2[2] = 32'h33; t2[3] = 32'h44;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_addr", rsp_addr, 32'd0);
        check("reset_rsp_instr", rsp_instr, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;

        // Latency of a single fetch; the array survives reset
        load(0, 32'h2008_0005);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        rsp_ready = 1'b1;
        send(32'h0040_0000, 32'h2008_0005, 1'b0, w);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!rsp_valid && lat < 10);
        check("t1_latency", 32'(lat), 32'd2);
        wait_drain();

        // Back-to-back streaming
        for (int i = 0; i < 4; i++) load(i, t2[i]);
        pop_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            send(32'h0040_0000 + 32'(4 * i), t2[i], 1'b0, w);
            check("t2_ready_wait", 32'(w), 32'd0);
        end
        wait_drain();
        check("t2_rsp_count", 32'(pop_cyc.size()), 32'd4);
        for (int i = 1; i < pop_cyc.size(); i++) begin
            check("t2_consecutive", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
        end

        // Back-pressure: three credits, then ready drops
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'h0040_0000 + 32'(4 * i), t2[i], 1'b0, w);
            check("t3_ready_wait", 32'(w), 32'd0);
        end
        req_valid = 1'b1;
        req_addr  = 32'h0040_000C;
        repeat (3) begin
            @(negedge clock);
            check("t3_backpressure", 32'(req_ready), 32'd0);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        check("t3_ready_before_pop", 32'(req_ready), 32'd0);
        @(negedge clock);
        check("t3_ready_after_pop", 32'(req_ready), 32'd1);
        wait_drain();

        // Error decoding and the top word
        load(1023, 32'hCAFE_F00D);
        send(32'h0040_0002, 32'h0000_0000, 1'b1, w);
        send(32'h003F_FFFC, 32'h0000_0000, 1'b1, w);
        send(32'h0040_1000, 32'h0000_0000, 1'b1, w);
        send(32'h0040_0FFC, 32'hCAFE_F00D, 1'b0, w);
        wait_drain();

        // Reset with responses in flight discards them
        rsp_ready = 1'b0;
        begin
            entry_t ea;
            req_valid = 1'b1;
            req_addr  = 32'h0040_0004;
            @(negedge clock);
            check("t5_accept_a", 32'(req_ready), 32'd1);
            ea.addr = 32'h0040_0004; ea.instr = 32'h22; ea.err = 1'b0;
            sb_q.push_back(ea);
            @(posedge clock);
            #1 req_addr = 32'h0040_0008;
            @(negedge clock);
            check("t5_accept_b", 32'(req_ready), 32'd1);
            @(posedge clock);
            #1;
            req_valid = 1'b0;
            reset     = 1'b1;
            @(posedge clock);
            #1;
            reset = 1'b0;
            sb_q.delete();
        end
        @(negedge clock);
        check("t5_rsp_valid_after_reset", 32'(rsp_valid), 32'd0);
        check("t5_req_ready_after_reset", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1 rsp_ready = 1'b1;
        repeat (10) begin
            @(negedge clock);
            check("t5_no_stale", 32'(rsp_valid), 32'd0);
        end
        @(posedge clock);
        #1;

        // Load and fetch of the same word on the same edge
        load(5, 32'hAAAA_AAAA);
        load_en    = 1'b1;
        load_index = 10'd5;
        load_data  = 32'h5555_5555;
        send(32'h0040_0014, 32'hAAAA_AAAA, 1'b0, w);
        load_en = 1'b0;
        send(32'h0040_0014, 32'h5555_5555, 1'b0, w);
        wait_drain();

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
